arith_result_buffer: RTL and testbench
======================================

ARITH_RESULT_BUFFER -- requirements
Module: arith_result_buffer

Interface
REQ-001 SHALL have parameter LATENCY, default 4, giving the cycles from operand issue to the matching result on y.
REQ-002 SHALL have parameter DEPTH, default 8, giving the result FIFO entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream presents operands a/b/c/d to the arithmetic unit this cycle.
REQ-006 SHALL have port in_ready  output  1  block can accept one more issue.
REQ-007 SHALL have port y  input  18  result bus of the 3-stage arithmetic unit ((A+B)*C)+D.
REQ-008 SHALL have port out_valid  output  1  FIFO head holds a result.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the head.
REQ-010 SHALL have port out_data  output  18  FIFO head result.
REQ-011 SHALL have port occupancy  output  $clog2(DEPTH)+1  stored result count.
REQ-012 SHALL have port inflight  output  $clog2(LATENCY)+1  issued results not yet written.

Function
REQ-013 SHALL define issue = in_valid & in_ready and pop = out_valid & out_ready.
REQ-014 SHALL track issues in a LATENCY-bit valid shift register: bit0 <= issue, bit[i] <= bit[i-1] on every clk edge.
REQ-015 SHALL write y into the FIFO tail on the edge where bit[LATENCY-1] is 1; an issue in cycle n writes the y present in cycle n+LATENCY.
REQ-016 SHALL drive inflight as the count of 1 bits in the valid shift register.
REQ-017 SHALL drive in_ready = (occupancy + inflight) < DEPTH, from registered state only, with no combinational path from out_ready or in_valid.
REQ-018 SHALL never overflow: a write SHALL always find a free entry, and no result SHALL be dropped.
REQ-019 SHALL drive out_valid = (occupancy != 0) and out_data = FIFO head; out_data SHALL hold stable while out_valid & !out_ready.
REQ-020 SHALL on simultaneous write and pop keep occupancy unchanged, advance both pointers, and return results in issue order.
REQ-021 SHALL wrap read/write pointers modulo DEPTH.
REQ-022 SHALL store y unmodified at 18 bits, with no truncation or saturation.
REQ-023 SHALL ignore out_ready when empty and ignore in_valid when in_ready=0 (no state change).

Reset
REQ-024 SHALL on rst=0 immediately clear the shift register, pointers and occupancy: out_valid=0, in_ready=1, occupancy=0, inflight=0, out_data=0.
REQ-025 SHALL discard results in flight at reset mid-operation; after release, the first write SHALL come only from a post-reset issue.
REQ-026 SHALL reset asynchronously and leave reset on the first clk edge with rst=1; FIFO storage contents need not be cleared.

Configuration
REQ-027 SHALL with ARITH_RESULT_BUF_ACC_EN defined add output acc, 24-bit, which adds out_data on every pop, wraps modulo 2^24, and resets to 0.
REQ-028 SHALL with ARITH_RESULT_BUF_ACC_EN undefined omit the acc port and its logic entirely; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL test single issue: a=3,b=4,c=5,d=6 issued in cycle 0 with out_ready=1 -> out_valid=1 in cycle 5 with out_data=41, inflight back to 0.
REQ-030 SHALL test maximum value: a=b=c=d=255 -> out_data=130305 (0x1FD01), no truncation.
REQ-031 SHALL test backpressure: out_ready=0 with in_valid held 1 -> exactly 8 issues accepted, in_ready=0 once occupancy+inflight=8, occupancy reaches 8, no loss; release out_ready -> 8 results popped in order.
REQ-032 SHALL test streaming: in_valid=1 and out_ready=1 for 100 cycles with distinct operands -> every result matches the reference model in order, and in_ready never drops after fill.
REQ-033 SHALL test reset mid-operation: rst=0 with 3 in flight and 2 stored -> outputs at reset values immediately; after release, no stale result ever appears.
REQ-034 SHALL test with ARITH_RESULT_BUF_ACC_EN defined: pop 41 then 130305 -> acc=130346; pops summing past 2^24 wrap modulo 2^24.

Source files
------------

// File: rtl/arith_result_buffer.sv
// Result FIFO that captures y from a fixed-latency arithmetic unit, with credit-based issue control.
// Optional build macro ARITH_RESULT_BUF_ACC_EN adds a 24-bit running sum of popped results on port acc.
module arith_result_buffer #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [17:0]                y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [17:0]                out_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [$clog2(LATENCY):0]   inflight
`ifdef ARITH_RESULT_BUF_ACC_EN
    ,
    output logic [23:0]                acc
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(LATENCY) + 1;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]      occ_q, occ_d;
    logic [IW-1:0]      inflight_cnt;
    logic [17:0]        mem_q [DEPTH];
    logic               issue;
    logic               pop;
    logic               wr_en;

    assign wr_en     = vld_q[LATENCY-1];
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid & out_ready;
    assign issue     = in_valid & in_ready;
    assign occupancy = occ_q;
    assign inflight  = inflight_cnt;
    // Results already stored plus those still in the pipe reserve every FIFO slot, so a write never overflows.
    assign in_ready  = (32'(occ_q) + 32'(inflight_cnt)) < 32'(DEPTH);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 18'd0;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_cnt = inflight_cnt + IW'(vld_q[i]);
        end
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_d    = occ_q + OW'(wr_en) - OW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is left uncleared on reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= y;
        end
    end

`ifdef ARITH_RESULT_BUF_ACC_EN
    logic [23:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q + (pop ? 24'(out_data) : 24'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
`endif

endmodule

// File: tb/tb_arith_result_buffer.sv
// Self-checking bench for arith_result_buffer: models the external ((A+B)*C)+D unit and the result queue.
// Build with ARITH_RESULT_BUF_ACC_EN defined to also check the accumulator.
module tb_arith_result_buffer;

   localparam int LAT = 4;
   localparam int DEP = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [17:0] y = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [17:0] out_data;
   logic [3:0]  occupancy;
   logic [2:0]  inflight;
`ifdef ARITH_RESULT_BUF_ACC_EN
   logic [23:0] acc;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Reference model: results owed by the arithmetic unit, and results held in the buffer
   int          flDue[$];
   logic [17:0] flVal[$];
   logic [17:0] stored[$];
   logic [23:0] accModel = '0;

   logic        lastValid;
   logic        lastReady;
   logic [17:0] lastData;
   logic [3:0]  lastOcc;

   arith_result_buffer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .y(y),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .occupancy(occupancy),
      .inflight(inflight)
`ifdef ARITH_RESULT_BUF_ACC_EN
      ,
      .acc(acc)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] refResult(input int a, input int b, input int c, input int d);
      return 18'(((a + b) * c) + d);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: called at posedge+1, drives inputs, checks at negedge, updates the model after the edge
   task automatic applyStimulus(input logic iv, input logic ordy, input int a, input int b, input int c, input int d);
      logic expRdy;
      logic doIssue;
      logic doPop;
      logic [17:0] val;
      in_valid  = iv;
      out_ready = ordy;
      if (flDue.size() > 0 && flDue[0] == cyc) y = flVal[0];
      else y = 18'($urandom);
      @(negedge clk);
      expRdy = (stored.size() + flDue.size()) < DEP;
      checkOutput("in_ready", in_ready, expRdy);
      checkOutput("out_valid", out_valid, stored.size() != 0);
      checkOutput("occupancy", occupancy, stored.size());
      checkOutput("inflight", inflight, flDue.size());
      checkOutput("out_data", out_data, (stored.size() != 0) ? stored[0] : 18'd0);
`ifdef ARITH_RESULT_BUF_ACC_EN
      checkOutput("acc", acc, accModel);
`endif
      lastValid = out_valid;
      lastReady = in_ready;
      lastData  = out_data;
      lastOcc   = occupancy;
      doIssue = iv && expRdy;
      doPop   = ordy && (stored.size() != 0);
      val = refResult(a, b, c, d);
      @(posedge clk);
      #1;
      if (doPop) begin
         accModel = accModel + 24'(stored[0]);
         void'(stored.pop_front());
      end
      if (flDue.size() > 0 && flDue[0] == cyc) begin
         stored.push_back(flVal[0]);
         void'(flDue.pop_front());
         void'(flVal.pop_front());
      end
      if (doIssue) begin
         flDue.push_back(cyc + LAT);
         flVal.push_back(val);
      end
      cyc++;
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, ordy, 0, 0, 0, 0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_in_ready"}, in_ready, 1);
      checkOutput({tag, "_occupancy"}, occupancy, 0);
      checkOutput({tag, "_inflight"}, inflight, 0);
      checkOutput({tag, "_out_data"}, out_data, 0);
`ifdef ARITH_RESULT_BUF_ACC_EN
      checkOutput({tag, "_acc"}, acc, 0);
`endif
   endtask

   initial begin
      int accepted;
      int popped;
      int drops;

      // Power-on reset
      #1;
      checkResetValues("por");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single issue 3,4,5,6: result visible five cycles after issue
      applyStimulus(1'b1, 1'b1, 3, 4, 5, 6);
      idle(4, 1'b1);
      checkOutput("single_early", lastValid, 0);
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 0);
      checkOutput("single_valid", lastValid, 1);
      checkOutput("single_data", lastData, 41);
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 0);
      checkOutput("single_inflight_done", inflight, 0);

      // Maximum operands, no truncation
      applyStimulus(1'b1, 1'b1, 255, 255, 255, 255);
      idle(4, 1'b1);
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 0);
      checkOutput("max_data", lastData, 130305);

      // Backpressure: downstream stalled, upstream always offering
      accepted = 0;
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b1, 1'b0, i, i + 1, i + 2, i + 3);
         if (lastReady) accepted++;
      end
      checkOutput("bp_accepted", accepted, 8);
      checkOutput("bp_occupancy", lastOcc, 8);
      checkOutput("bp_in_ready", lastReady, 0);
      popped = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, 0, 0, 0, 0);
         if (lastValid) popped++;
      end
      checkOutput("bp_popped", popped, 8);

      // Streaming with random operands; in_ready must stay high
      drops = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, 1'b1, i % 256, $urandom_range(255), $urandom_range(255), $urandom_range(255));
         if (!lastReady) drops++;
      end
      checkOutput("stream_ready_drops", drops, 0);
      idle(6, 1'b1);

      // Random valid/ready traffic
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'($urandom_range(1)), 1'($urandom_range(3) != 0),
                       $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
      end
      idle(14, 1'b1);

      // Reset with three results in flight and two stored
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 10 + i, 1, 2, 3);
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
      checkOutput("pre_rst_occupancy", occupancy, 2);
      checkOutput("pre_rst_inflight", inflight, 3);
      rst = 1'b0;
      #1;
      checkResetValues("mid_rst");
      flDue.delete();
      flVal.delete();
      stored.delete();
      accModel = '0;
      @(posedge clk);
      y = 18'($urandom);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc++;
      cyc++;
      idle(12, 1'b1);

      // Post-reset: first write must come from a fresh issue
      applyStimulus(1'b1, 1'b1, 3, 4, 5, 6);
      applyStimulus(1'b1, 1'b1, 255, 255, 255, 255);
      idle(3, 1'b1);
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 0);
      checkOutput("post_rst_first", lastData, 41);
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 0);
      checkOutput("post_rst_second", lastData, 130305);
      idle(2, 1'b1);
`ifdef ARITH_RESULT_BUF_ACC_EN
      checkOutput("acc_pair", acc, 130346);
      // Enough maximum results to carry the sum past 2^24
      for (int i = 0; i < 140; i++) applyStimulus(1'b1, 1'b1, 255, 255, 255, 255);
      idle(8, 1'b1);
      checkOutput("acc_wrap", acc, 24'((130346 + 140 * 130305) % (1 << 24)));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
